// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx peripheral: register map, STATUS bit
// positions and receive-FSM state encoding.
package uart_rx_pkg;

    localparam logic [31:0] REG_DATA   = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;

    localparam int STATUS_NOT_EMPTY = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERRUN   = 2;
    localparam int STATUS_FRAME_ERR = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Width of a down-counter that must hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver on the picorv32 native bus: synchroniser,
// deframing FSM, receive FIFO and DATA/STATUS registers.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic        serialIn,
    output logic        rx_irq
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = cnt_width(BIT_CYCLES);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CYCLES);

    logic            sync_0;
    logic            rxs;
    rx_state_t       state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            push_req;
    logic            frame_set;
    logic            cnt_expired;

    logic            frame_err;
    logic            overrun;
    logic            ack_pending;
    logic            req;
    logic            is_write;
    logic            is_status;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [7:0]      fifo_dout;
    logic            overrun_set;
    logic            clr_frame;
    logic            clr_overrun;
    logic [31:0]     status_word;
    logic            unused_bus_bits;

    assign unused_bus_bits = ^{mem_instr, mem_wdata[31:4], mem_wdata[1:0],
                               mem_addr[31:3], mem_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_0 <= serialIn;
            rxs    <= sync_0;
        end
    end

    assign cnt_expired = (bit_cnt == CNT_ONE);

    // Start bit is re-checked at mid-bit; every later sample lands mid-bit too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            push_req  <= 1'b0;
            frame_set <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_set <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        bit_cnt <= CNT_HALF;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_expired) begin
                        if (!rxs) begin
                            bit_cnt <= CNT_BIT;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_expired) begin
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_cnt   <= CNT_BIT;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_expired) begin
                        if (rxs) begin
                            push_req <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            frame_set <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (shift_reg),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign req         = mem_valid && enable && !ack_pending;
    assign is_write    = |mem_wstrb;
    assign is_status   = mem_addr[2];
    assign fifo_pop    = req && !is_write && !is_status && !fifo_empty;
    assign clr_frame   = req && is_status && mem_wstrb[0] && mem_wdata[3];
    assign clr_overrun = req && is_status && mem_wstrb[0] && mem_wdata[2];
    assign overrun_set = push_req && fifo_full && !fifo_pop;
    assign rx_irq      = !fifo_empty;

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_NOT_EMPTY] = !fifo_empty;
        status_word[STATUS_FULL]      = fifo_full;
        status_word[STATUS_OVERRUN]   = overrun;
        status_word[STATUS_FRAME_ERR] = frame_err;
    end

    // The ack is held off until mem_valid drops so a stretched request pops once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            ack_pending <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            mem_ready <= req;
            if (req) ack_pending <= 1'b1;
            else if (!mem_valid) ack_pending <= 1'b0;

            if (req && !is_write) begin
                if (is_status) mem_rdata <= status_word;
                else if (fifo_empty) mem_rdata <= '0;
                else mem_rdata <= {24'h0, fifo_dout};
            end else begin
                mem_rdata <= '0;
            end

            if (frame_set) frame_err <= 1'b1;
            else if (clr_frame) frame_err <= 1'b0;

            if (overrun_set) overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx, compared against a queue-based
// model of the receive FIFO and sticky flags.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD       = 100000;
    localparam int BIT_CYCLES = 16;
    localparam int FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        serial_line;
    logic        rx_irq;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    logic [7:0] model_q [$];
    logic       model_overrun;
    logic       model_frame_err;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .serialIn  (serial_line),
        .rx_irq    (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s    = '0;
        s[0] = (model_q.size() != 0);
        s[1] = (model_q.size() == FIFO_DEPTH);
        s[2] = model_overrun;
        s[3] = model_frame_err;
        return s;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; the model learns the outcome once the stop bit is over.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        @(negedge clk);
        serial_line = 1'b0;
        repeat (BIT_CYCLES) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_line = data[i];
            repeat (BIT_CYCLES) @(negedge clk);
        end
        serial_line = stop_bit;
        repeat (BIT_CYCLES) @(negedge clk);
        if (stop_bit) begin
            if (model_q.size() == FIFO_DEPTH) model_overrun = 1'b1;
            else model_q.push_back(data);
            idle_cycles(2);
        end else begin
            model_frame_err = 1'b1;
        end
    endtask

    task automatic bus_access(input logic [31:0] addr, input logic [3:0] wstrb,
                              input logic [31:0] wdata, output logic [31:0] rdata);
        int cycles;
        logic got;
        @(negedge clk);
        mem_valid = 1'b1;
        enable    = 1'b1;
        mem_addr  = addr;
        mem_wstrb = wstrb;
        mem_wdata = wdata;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 10) begin
            @(negedge clk);
            cycles++;
            got = mem_ready;
        end
        checkOutput("ack_latency", 32'(cycles), 32'd1);
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        enable    = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = '0;
        @(negedge clk);
        checkOutput("ack_single_cycle", {31'h0, mem_ready}, 32'h0);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] rd;
        logic [31:0] exp;
        bus_access(REG_DATA, 4'h0, 32'h0, rd);
        exp = (model_q.size() != 0) ? {24'h0, model_q.pop_front()} : 32'h0;
        checkOutput(tag, rd, exp);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] rd;
        logic [31:0] exp;
        exp = model_status();
        bus_access(REG_STATUS, 4'h0, 32'h0, rd);
        checkOutput(tag, rd, exp);
    endtask

    task automatic write_status(input logic [31:0] value);
        logic [31:0] rd;
        bus_access(REG_STATUS, 4'h1, value, rd);
        checkOutput("status_write_rdata", rd, 32'h0);
        if (value[3]) model_frame_err = 1'b0;
        if (value[2]) model_overrun = 1'b0;
    endtask

    task automatic check_irq(input string tag);
        checkOutput(tag, {31'h0, rx_irq}, {31'h0, model_q.size() != 0});
    endtask

    initial begin
        logic [7:0] rnd_byte;
        int acks;
        int first_ack;
        logic [31:0] held_rdata;

        reset       = 1'b1;
        enable      = 1'b0;
        mem_valid   = 1'b0;
        mem_instr   = 1'b0;
        mem_wstrb   = 4'h0;
        mem_wdata   = '0;
        mem_addr    = '0;
        serial_line = 1'b1;
        model_overrun   = 1'b0;
        model_frame_err = 1'b0;
        idle_cycles(3);
        checkOutput("reset_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("reset_rdata", mem_rdata, 32'h0);
        checkOutput("reset_irq", {31'h0, rx_irq}, 32'h0);
        reset = 1'b0;
        idle_cycles(3);
        read_status("status_after_reset");

        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5, 1'b1);
        read_status("status_a5_pending");
        check_irq("irq_a5_pending");
        read_data("data_a5");
        read_status("status_a5_drained");
        check_irq("irq_a5_drained");

        $display("[TB] start-bit glitch");
        @(negedge clk);
        serial_line = 1'b0;
        idle_cycles(4);
        serial_line = 1'b1;
        idle_cycles(40);
        read_status("status_glitch");
        check_irq("irq_glitch");

        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 1'b0);
        read_status("status_frame_err");
        idle_cycles(100);
        serial_line = 1'b1;
        idle_cycles(20);
        applyStimulus(8'h11, 1'b1);
        read_data("data_after_break");
        write_status(32'h8);
        read_status("status_frame_err_cleared");

        $display("[TB] overrun with 17 bytes");
        for (int b = 0; b < 17; b++) applyStimulus(8'(b), 1'b1);
        read_status("status_overrun_full");
        check_irq("irq_full");
        for (int r = 0; r < 17; r++) read_data($sformatf("data_overrun_%0d", r));
        read_status("status_overrun_drained");
        write_status(32'h4);
        read_status("status_overrun_cleared");

        $display("[TB] held request on empty FIFO");
        @(negedge clk);
        mem_valid = 1'b1;
        enable    = 1'b1;
        mem_addr  = REG_DATA;
        mem_wstrb = 4'h0;
        acks       = 0;
        first_ack  = -1;
        held_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                acks++;
                if (first_ack < 0) begin
                    first_ack  = c;
                    held_rdata = mem_rdata;
                end
            end
        end
        mem_valid = 1'b0;
        enable    = 1'b0;
        checkOutput("held_ack_count", 32'(acks), 32'd1);
        checkOutput("held_first_ack", 32'(first_ack), 32'd0);
        checkOutput("held_rdata", held_rdata, 32'h0);
        idle_cycles(2);

        $display("[TB] randomized bytes");
        for (int k = 0; k < 8; k++) begin
            rnd_byte = 8'($urandom_range(0, 255));
            applyStimulus(rnd_byte, 1'b1);
            check_irq($sformatf("irq_rand_%0d", k));
            if ($urandom_range(0, 1) == 1) read_data($sformatf("data_rand_%0d", k));
        end
        read_status("status_rand");
        while (model_q.size() != 0) read_data("data_rand_drain");
        read_status("status_rand_drained");

        $display("[TB] reset mid-frame");
        applyStimulus(8'h77, 1'b1);
        check_irq("irq_before_reset");
        @(negedge clk);
        serial_line = 1'b0;
        idle_cycles(BIT_CYCLES);
        serial_line = 1'b1;
        idle_cycles(4 * BIT_CYCLES + BIT_CYCLES / 2);
        reset = 1'b1;
        idle_cycles(1);
        model_q.delete();
        model_overrun   = 1'b0;
        model_frame_err = 1'b0;
        checkOutput("midreset_ready", {31'h0, mem_ready}, 32'h0);
        checkOutput("midreset_rdata", mem_rdata, 32'h0);
        checkOutput("midreset_irq", {31'h0, rx_irq}, 32'h0);
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(5 * BIT_CYCLES);
        read_status("status_after_midreset");
        applyStimulus(8'h5A, 1'b1);
        read_data("data_5a");
        read_status("status_final");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
